// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_pkg
// Brief    : Shared AHB-Lite transfer encodings and arbiter owner states.
// Revision : 1.0
// ============================================================================
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    // NONSEQ and SEQ both carry bit 1; IDLE and BUSY do not.
    function automatic logic is_req(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_bram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bram_arbiter_if
// Brief    : Two AHB-Lite master ports and one memory-slave port of the arbiter.
// Revision : 1.0
// ============================================================================
interface ahb_bram_arbiter_if;

    logic [31:0] M0_HADDR;
    logic [1:0]  M0_HTRANS;
    logic        M0_HWRITE;
    logic [2:0]  M0_HSIZE;
    logic [31:0] M0_HWDATA;
    logic        M0_HREADY;
    logic [31:0] M0_HRDATA;
    logic        M0_HRESP;

    logic [31:0] M1_HADDR;
    logic [1:0]  M1_HTRANS;
    logic        M1_HWRITE;
    logic [2:0]  M1_HSIZE;
    logic [31:0] M1_HWDATA;
    logic        M1_HREADY;
    logic [31:0] M1_HRDATA;
    logic        M1_HRESP;

    logic        S_HSEL;
    logic [31:0] S_HADDR;
    logic [1:0]  S_HTRANS;
    logic        S_HWRITE;
    logic [2:0]  S_HSIZE;
    logic [31:0] S_HWDATA;
    logic        S_HREADY;
    logic        S_HREADYOUT;
    logic [31:0] S_HRDATA;

    // Arbiter view: it is the slave of both masters and drives the memory port.
    modport slave (
        input  M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HWDATA,
        output M0_HREADY, M0_HRDATA, M0_HRESP,
        input  M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HWDATA,
        output M1_HREADY, M1_HRDATA, M1_HRESP,
        output S_HSEL, S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HWDATA, S_HREADY,
        input  S_HREADYOUT, S_HRDATA
    );

    modport master (
        output M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE, M0_HWDATA,
        input  M0_HREADY, M0_HRDATA, M0_HRESP,
        output M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE, M1_HWDATA,
        input  M1_HREADY, M1_HRDATA, M1_HRESP,
        input  S_HSEL, S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HWDATA, S_HREADY,
        output S_HREADYOUT, S_HRDATA
    );

endinterface
`default_nettype wire

// File: rtl/ahb_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ahb_bram_arbiter
// Brief    : Two-master AHB-Lite arbiter in front of a single memory slave.
// Revision : 1.0
// ============================================================================
module ahb_bram_arbiter
    import ahb_pkg::*;
#(
    parameter bit DEFAULT_OWNER = 1'b0
) (
    input  wire logic         HCLK,
    input  wire logic         HRESET,
    ahb_bram_arbiter_if.slave bus,
    output logic              HMASTER,
    output logic              HMASTER_D
);

    localparam owner_e C_RST_OWNER = DEFAULT_OWNER ? OWN_M1 : OWN_M0;

    owner_e state_q, state_d;
    logic   hmaster_d_q, hmaster_d_d;
    logic   w_m1_own;
    logic   w_own_req;
    logic   w_oth_req;

    assign w_m1_own  = (state_q == OWN_M1);
    assign w_own_req = w_m1_own ? is_req(bus.M1_HTRANS) : is_req(bus.M0_HTRANS);
    assign w_oth_req = w_m1_own ? is_req(bus.M0_HTRANS) : is_req(bus.M1_HTRANS);

    // Handover only at a bus-ready boundary where the owner has released;
    // an owner that keeps requesting is never preempted.
    always_comb begin
        state_d     = state_q;
        hmaster_d_d = hmaster_d_q;
        if (bus.S_HREADYOUT) begin
            hmaster_d_d = w_m1_own;
            if (!w_own_req) begin
                if (w_oth_req) begin
                    state_d = w_m1_own ? OWN_M0 : OWN_M1;
                end else begin
                    state_d = C_RST_OWNER;
                end
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= C_RST_OWNER;
            hmaster_d_q <= (C_RST_OWNER == OWN_M1);
        end else begin
            state_q     <= state_d;
            hmaster_d_q <= hmaster_d_d;
        end
    end

    assign HMASTER   = w_m1_own;
    assign HMASTER_D = hmaster_d_q;

    assign bus.S_HSEL   = w_own_req;
    assign bus.S_HADDR  = w_m1_own ? bus.M1_HADDR  : bus.M0_HADDR;
    assign bus.S_HTRANS = w_m1_own ? bus.M1_HTRANS : bus.M0_HTRANS;
    assign bus.S_HWRITE = w_m1_own ? bus.M1_HWRITE : bus.M0_HWRITE;
    assign bus.S_HSIZE  = w_m1_own ? bus.M1_HSIZE  : bus.M0_HSIZE;
    assign bus.S_HWDATA = hmaster_d_q ? bus.M1_HWDATA : bus.M0_HWDATA;
    assign bus.S_HREADY = bus.S_HREADYOUT;

    // A requesting non-owner stalls with its address held; an idle one never waits.
    assign bus.M0_HREADY = w_m1_own ? ~bus.M0_HTRANS[1] : bus.S_HREADYOUT;
    assign bus.M1_HREADY = w_m1_own ? bus.S_HREADYOUT   : ~bus.M1_HTRANS[1];

    assign bus.M0_HRDATA = bus.S_HRDATA;
    assign bus.M1_HRDATA = bus.S_HRDATA;
    assign bus.M0_HRESP  = 1'b0;
    assign bus.M1_HRESP  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_bram_arbiter
// Brief    : Directed scoreboard bench for ahb_bram_arbiter with a BRAM model.
// Revision : 1.0
// ============================================================================
module tb_ahb_bram_arbiter;
    import ahb_pkg::*;

    logic HCLK;
    logic HRESET;
    logic hready_s;
    logic hm0, hmd0, hm1, hmd1;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    localparam logic [31:0] D0 = 32'hA5A5_0000;
    localparam logic [31:0] D1 = 32'hA5A5_0004;
    localparam logic [31:0] D2 = 32'hA5A5_0008;
    localparam logic [31:0] W0 = 32'h1111_0010;
    localparam logic [31:0] W1 = 32'h2222_0014;

    ahb_bram_arbiter_if bus0();
    ahb_bram_arbiter_if bus1();

    ahb_bram_arbiter #(.DEFAULT_OWNER(1'b0)) dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus0), .HMASTER(hm0), .HMASTER_D(hmd0)
    );
    ahb_bram_arbiter #(.DEFAULT_OWNER(1'b1)) dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .bus(bus1), .HMASTER(hm1), .HMASTER_D(hmd1)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // Memory slave: unwritten words read back as 0x5A000000 | word index.
    logic [31:0]  mem [256];
    logic [255:0] wr_vld = '0;
    logic         dp_vld, dp_wr;
    logic [7:0]   dp_idx;

    always @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_vld <= 1'b0;
            dp_wr  <= 1'b0;
            dp_idx <= 8'h0;
        end else if (hready_s) begin
            dp_vld <= bus0.S_HSEL;
            dp_wr  <= bus0.S_HWRITE;
            dp_idx <= bus0.S_HADDR[9:2];
        end
    end

    always @(posedge HCLK) begin
        if (!HRESET && hready_s && dp_vld && dp_wr) begin
            mem[dp_idx]    <= bus0.S_HWDATA;
            wr_vld[dp_idx] <= 1'b1;
        end
    end

    assign bus0.S_HREADYOUT = hready_s;
    assign bus0.S_HRDATA    = wr_vld[dp_idx] ? mem[dp_idx] : (32'h5A00_0000 | {24'h0, dp_idx});
    assign bus1.S_HREADYOUT = 1'b1;
    assign bus1.S_HRDATA    = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Read-data monitor: a data phase completes on an edge where the master's HREADY is high.
    initial begin
        logic pend0, pend1;
        pend0 = 1'b0;
        pend1 = 1'b0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                pend0 = 1'b0;
                pend1 = 1'b0;
            end else begin
                if (bus0.M0_HREADY) begin
                    if (pend0) begin
                        if (exp_q0.size() == 0) chk("m0_rdata_unexpected", bus0.M0_HRDATA, 32'hxxxx_xxxx);
                        else chk("m0_rdata", bus0.M0_HRDATA, exp_q0.pop_front());
                    end
                    pend0 = bus0.M0_HTRANS[1] && !bus0.M0_HWRITE;
                end
                if (bus0.M1_HREADY) begin
                    if (pend1) begin
                        if (exp_q1.size() == 0) chk("m1_rdata_unexpected", bus0.M1_HRDATA, 32'hxxxx_xxxx);
                        else chk("m1_rdata", bus0.M1_HRDATA, exp_q1.pop_front());
                    end
                    pend1 = bus0.M1_HTRANS[1] && !bus0.M1_HWRITE;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drv0(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic [31:0] wd);
        bus0.M0_HTRANS = tr; bus0.M0_HADDR = a; bus0.M0_HWRITE = wr;
        bus0.M0_HWDATA = wd; bus0.M0_HSIZE = 3'b010;
    endtask

    task automatic drv1(input logic [1:0] tr, input logic [31:0] a, input logic wr, input logic [31:0] wd);
        bus0.M1_HTRANS = tr; bus0.M1_HADDR = a; bus0.M1_HWRITE = wr;
        bus0.M1_HWDATA = wd; bus0.M1_HSIZE = 3'b010;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        HRESET   = 1'b1;
        hready_s = 1'b1;
        drv0(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
        drv1(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
        bus1.M0_HTRANS = HTRANS_IDLE; bus1.M0_HADDR = 32'h0; bus1.M0_HWRITE = 1'b0;
        bus1.M0_HSIZE  = 3'b010;      bus1.M0_HWDATA = 32'h0;
        bus1.M1_HTRANS = HTRANS_IDLE; bus1.M1_HADDR = 32'h0; bus1.M1_HWRITE = 1'b0;
        bus1.M1_HSIZE  = 3'b010;      bus1.M1_HWDATA = 32'h0;
        #2;
        chk("rst_hmaster", hm0, 0);
        chk("rst_hmaster_d", hmd0, 0);
        chk("rst_hsel", bus0.S_HSEL, 0);
        chk("rst_m0_hready", bus0.M0_HREADY, 1);
        chk("rst_hresp", {bus0.M0_HRESP, bus0.M1_HRESP}, 0);
        chk("rst_dflt1_hmaster", hm1, 1);
        chk("rst_dflt1_hmaster_d", hmd1, 1);
        cyc(); cyc();
        HRESET = 1'b0;

        // M0 alone: three back-to-back zero-wait writes, then read back.
        drv0(HTRANS_NONSEQ, 32'h0, 1'b1, 32'h0);
        #1 chk("wr0_hmaster", hm0, 0); chk("wr0_hready", bus0.M0_HREADY, 1);
        cyc(); drv0(HTRANS_NONSEQ, 32'h4, 1'b1, D0);
        #1 chk("wr1_hmaster", hm0, 0); chk("wr1_hready", bus0.M0_HREADY, 1);
        chk("wr1_hwdata", bus0.S_HWDATA, D0);
        cyc(); drv0(HTRANS_NONSEQ, 32'h8, 1'b1, D1);
        #1 chk("wr2_hmaster", hm0, 0); chk("wr2_hwdata", bus0.S_HWDATA, D1);
        cyc(); drv0(HTRANS_IDLE, 32'h0, 1'b0, D2);
        #1 chk("wr3_hready", bus0.M0_HREADY, 1); chk("wr3_hwdata", bus0.S_HWDATA, D2);
        cyc(); drv0(HTRANS_NONSEQ, 32'h0, 1'b0, 32'h0); exp_q0.push_back(D0);
        cyc(); drv0(HTRANS_NONSEQ, 32'h4, 1'b0, 32'h0); exp_q0.push_back(D1);
        cyc(); drv0(HTRANS_NONSEQ, 32'h8, 1'b0, 32'h0); exp_q0.push_back(D2);
        cyc(); drv0(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);

        // M1 read waits out an M0 4-beat burst.
        cyc();
        drv0(HTRANS_NONSEQ, 32'h0, 1'b0, 32'h0);   exp_q0.push_back(D0);
        drv1(HTRANS_NONSEQ, 32'h100, 1'b0, 32'h0); exp_q1.push_back(32'h5A00_0040);
        #1 chk("bst0_m1_hready", bus0.M1_HREADY, 0); chk("bst0_hmaster", hm0, 0);
        chk("bst0_haddr", bus0.S_HADDR, 32'h0);
        cyc(); drv0(HTRANS_SEQ, 32'h4, 1'b0, 32'h0); exp_q0.push_back(D1);
        #1 chk("bst1_m1_hready", bus0.M1_HREADY, 0);
        cyc(); drv0(HTRANS_SEQ, 32'h8, 1'b0, 32'h0); exp_q0.push_back(D2);
        #1 chk("bst2_m1_hready", bus0.M1_HREADY, 0);
        cyc(); drv0(HTRANS_SEQ, 32'hC, 1'b0, 32'h0); exp_q0.push_back(32'h5A00_0003);
        #1 chk("bst3_m1_hready", bus0.M1_HREADY, 0); chk("bst3_hmaster", hm0, 0);
        cyc(); drv0(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
        #1 chk("rel_m1_hready", bus0.M1_HREADY, 0); chk("rel_hmaster", hm0, 0);
        cyc();
        #1 chk("grant1_hmaster", hm0, 1); chk("grant1_haddr", bus0.S_HADDR, 32'h100);
        chk("grant1_m1_hready", bus0.M1_HREADY, 1); chk("grant1_hsel", bus0.S_HSEL, 1);
        cyc(); drv1(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
        #1 chk("m1dp_hmaster", hm0, 1);
        cyc();
        #1 chk("park0_hmaster", hm0, 0); chk("park0_hmaster_d", hmd0, 1);

        // Owner releases while the other requests; then a stalled data phase.
        cyc();
        drv0(HTRANS_NONSEQ, 32'h10, 1'b1, 32'h0);
        drv1(HTRANS_NONSEQ, 32'h14, 1'b1, 32'h0);
        #1 chk("rr0_hmaster", hm0, 0); chk("rr0_m1_hready", bus0.M1_HREADY, 0);
        cyc(); drv0(HTRANS_IDLE, 32'h0, 1'b0, W0);
        #1 chk("rr1_m1_hready", bus0.M1_HREADY, 0); chk("rr1_hwdata", bus0.S_HWDATA, W0);
        cyc(); drv0(HTRANS_NONSEQ, 32'h10, 1'b0, 32'h0); exp_q0.push_back(W0);
        #1 chk("rr2_hmaster", hm0, 1); chk("rr2_m0_hready", bus0.M0_HREADY, 0);
        chk("rr2_m1_hready", bus0.M1_HREADY, 1); chk("rr2_haddr", bus0.S_HADDR, 32'h14);
        cyc(); drv1(HTRANS_IDLE, 32'h0, 1'b0, W1); hready_s = 1'b0;
        #1 chk("ws0_hmaster", hm0, 1); chk("ws0_hmaster_d", hmd0, 1);
        chk("ws0_hwdata", bus0.S_HWDATA, W1); chk("ws0_m1_hready", bus0.M1_HREADY, 0);
        chk("ws0_m0_hready", bus0.M0_HREADY, 0);
        cyc();
        #1 chk("ws1_hmaster", hm0, 1); chk("ws1_hmaster_d", hmd0, 1);
        cyc(); hready_s = 1'b1;
        #1 chk("ws2_hmaster", hm0, 1); chk("ws2_m1_hready", bus0.M1_HREADY, 1);
        chk("ws2_m0_hready", bus0.M0_HREADY, 0);
        cyc();
        #1 chk("sw_hmaster", hm0, 0); chk("sw_hmaster_d", hmd0, 1);
        chk("sw_haddr", bus0.S_HADDR, 32'h10); chk("sw_m0_hready", bus0.M0_HREADY, 1);
        cyc(); drv0(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
        drv1(HTRANS_NONSEQ, 32'h14, 1'b0, 32'h0); exp_q1.push_back(W1);
        #1 chk("rb_hmaster_d", hmd0, 0); chk("rb_m1_hready", bus0.M1_HREADY, 0);
        cyc();
        #1 chk("rb_hmaster", hm0, 1);
        cyc(); drv1(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);

        // Reset while M1 owns the bus mid-transfer.
        cyc(); drv1(HTRANS_NONSEQ, 32'h100, 1'b0, 32'h0);
        #1 chk("pre_rst_hmaster", hm0, 0);
        cyc();
        #1 chk("own1_hmaster", hm0, 1);
        cyc();
        #1 chk("own1_hmaster_d", hmd0, 1);
        HRESET = 1'b1;
        #1 chk("arst_hmaster", hm0, 0); chk("arst_hmaster_d", hmd0, 0);
        drv1(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
        cyc(); cyc();
        HRESET = 1'b0;
        drv0(HTRANS_NONSEQ, 32'h0, 1'b0, 32'h0); exp_q0.push_back(D0);
        #1 chk("post_rst_hmaster", hm0, 0); chk("post_rst_m0_hready", bus0.M0_HREADY, 1);
        cyc(); drv0(HTRANS_IDLE, 32'h0, 1'b0, 32'h0);
        cyc();

        // DEFAULT_OWNER=1 instance: parks at M1 when idle.
        for (int i = 0; i < 5; i++) cyc();
        chk("park1_hmaster", hm1, 1); chk("park1_hsel", bus1.S_HSEL, 0);
        chk("park1_hmaster_d", hmd1, 1);
        bus1.M0_HTRANS = HTRANS_NONSEQ;
        #1 chk("d1_req_m0_hready", bus1.M0_HREADY, 0); chk("d1_req_hmaster", hm1, 1);
        cyc();
        #1 chk("d1_grant_hmaster", hm1, 0); chk("d1_grant_hsel", bus1.S_HSEL, 1);
        cyc(); bus1.M0_HTRANS = HTRANS_IDLE;
        #1 chk("d1_idle_hmaster", hm1, 0);
        cyc();
        #1 chk("d1_repark_hmaster", hm1, 1); chk("d1_repark_hsel", bus1.S_HSEL, 0);

        cyc(); cyc();
        chk("m0_queue_drained", exp_q0.size(), 0);
        chk("m1_queue_drained", exp_q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_bram_arbiter.md
AHB_BRAM_ARBITER -- requirements
Module: ahb_bram_arbiter

Interface
REQ-001 Parameter DEFAULT_OWNER, 0: master that owns the bus after reset and when both masters are idle (0 = M0 CPU, 1 = M1 loader/DMA).
REQ-002 The clock and reset SHALL be one clock and an asynchronous, active-high reset, named HCLK and HRESET.
REQ-003 HCLK  in  1  AHB-Lite clock; all state changes on the rising edge.
REQ-004 HRESET  in  1  asynchronous, active-high reset.
REQ-005 Mx_HADDR  in  32  address from master x (x = 0, 1).
REQ-006 Mx_HTRANS  in  2  transfer type from master x.
REQ-007 Mx_HWRITE  in  1  write flag from master x.
REQ-008 Mx_HSIZE  in  3  transfer size from master x.
REQ-009 Mx_HWDATA  in  32  write data from master x.
REQ-010 Mx_HREADY  out  1  ready returned to master x.
REQ-011 Mx_HRDATA  out  32  read data returned to master x.
REQ-012 Mx_HRESP  out  1  response to master x; constant 0 (OKAY).
REQ-013 S_HSEL, S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE  out  1/32/2/1/3  muxed address phase to the memory slave.
REQ-014 S_HWDATA  out  32  muxed write data to the slave.
REQ-015 S_HREADY  out  1  bus ready to the slave; equals S_HREADYOUT.
REQ-016 S_HREADYOUT  in  1  slave ready.
REQ-017 S_HRDATA  in  32  slave read data.
REQ-018 HMASTER  out  1  current address-phase owner.
REQ-019 HMASTER_D  out  1  current data-phase owner.

Function
REQ-020 State machine with two states, OWN_M0 and OWN_M1; the state is the address-phase owner and drives HMASTER.
REQ-021 Request from master x = Mx_HTRANS[1] (NONSEQ or SEQ).
REQ-022 Ownership SHALL transfer only on an edge where S_HREADYOUT=1, the owner's HTRANS[1]=0 (IDLE/BUSY), and the other master requests; otherwise the state holds (no preemption of a burst).
REQ-023 When both masters are idle with S_HREADYOUT=1, the state SHALL park at DEFAULT_OWNER.
REQ-024 S_HADDR/S_HTRANS/S_HWRITE/S_HSIZE SHALL select the owner's signals combinationally; S_HSEL = owner's HTRANS[1].
REQ-025 HMASTER_D SHALL load HMASTER on every edge with S_HREADYOUT=1, and hold otherwise.
REQ-026 S_HWDATA SHALL select Mx_HWDATA of HMASTER_D.
REQ-027 Owner: Mx_HREADY = S_HREADYOUT. Non-owner: Mx_HREADY = ~Mx_HTRANS[1], so a requesting non-owner stalls with its address held and an idle non-owner is never blocked.
REQ-028 Mx_HRDATA = S_HRDATA for both masters; validity is qualified by each master's own HREADY.
REQ-029 Arbitration adds zero wait states for the owner; a switch costs exactly one cycle (the owner's idle cycle) before the new master's address appears on S_HADDR.
REQ-030 A simultaneous release by the owner and requests from both masters SHALL grant the non-owner (round-robin on release).

Reset
REQ-031 On HRESET: state = DEFAULT_OWNER and HMASTER_D = DEFAULT_OWNER, immediately and asynchronously; combinational outputs follow from these.
REQ-032 Reset mid-transfer SHALL abandon any in-flight data phase; there is no pending-request memory to clear.

Structure
REQ-033 The OWN_M0/OWN_M1 encodings and the HTRANS constants (IDLE, BUSY, NONSEQ, SEQ) SHALL live in a shared package ahb_pkg.
REQ-034 A single flat module; no sub-module.

Verification
REQ-035 M0 only, back-to-back word writes to 0x0, 0x4, 0x8 -> three zero-wait transfers, HMASTER=0 throughout, memory holds the data.
REQ-036 M1 NONSEQ read of 0x100 while M0 runs a 4-beat SEQ burst -> M1_HREADY=0 through the burst; M1 granted in the cycle after M0 goes IDLE; M1 sees the correct data.
REQ-037 Both masters request with M0 idle at the same edge and owner=0 -> ownership moves to M1 (REQ-030).
REQ-038 S_HREADYOUT forced low for 2 cycles during M1's data phase while M0 requests -> no switch until S_HREADYOUT=1; HMASTER_D remains 1.
REQ-039 HRESET asserted mid-transfer with owner=1 -> HMASTER=HMASTER_D=DEFAULT_OWNER in the same cycle; M0 is granted after release.
REQ-040 Both masters idle for 5 cycles with DEFAULT_OWNER=1 -> bus parks at M1 and S_HSEL=0.
